// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 8-bit words over req/ready and
// presents them to the decoder. Optional one-entry prefetch buffer: FETCH_PREFETCH_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic                  instr_valid,
  output logic [4:0]            opcode,
  output logic [2:0]            operand,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ack,
  input  logic                  pc_load_en,
  input  logic [ADDR_WIDTH-1:0] pc_load_value
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] instr_pc_reg, instr_pc_next;
  logic [7:0]            ir_reg, ir_next;
`ifdef FETCH_PREFETCH_EN
  logic [7:0]            pf_data_reg, pf_data_next;
  logic                  pf_valid_reg, pf_valid_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_pc_reg <= '0;
      ir_reg       <= 8'h00;
`ifdef FETCH_PREFETCH_EN
      pf_data_reg  <= 8'h00;
      pf_valid_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_pc_reg <= instr_pc_next;
      ir_reg       <= ir_next;
`ifdef FETCH_PREFETCH_EN
      pf_data_reg  <= pf_data_next;
      pf_valid_reg <= pf_valid_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_pc_next = instr_pc_reg;
    ir_next       = ir_reg;
    mem_req       = 1'b0;
`ifdef FETCH_PREFETCH_EN
    pf_data_next  = pf_data_reg;
    pf_valid_next = pf_valid_reg;
`endif
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_next       = mem_rdata;
          instr_pc_next = pc_reg;
          pc_next       = pc_reg + PC_ONE;
          state_next    = VALID;
        end
      end
      VALID: begin
`ifdef FETCH_PREFETCH_EN
        mem_req = !pf_valid_reg;
        if (instr_ack && pc_load_en) begin
          pc_next       = pc_load_value;
          pf_valid_next = 1'b0;
          state_next    = FETCH;
        end else if (instr_ack && pf_valid_reg) begin
          ir_next       = pf_data_reg;
          instr_pc_next = pc_reg - PC_ONE;
          pf_valid_next = 1'b0;
        end else if (instr_ack && mem_ready) begin
          // Word arriving in the retire cycle goes straight to the IR so issue stays back-to-back.
          ir_next       = mem_rdata;
          instr_pc_next = pc_reg;
          pc_next       = pc_reg + PC_ONE;
        end else if (instr_ack) begin
          state_next    = FETCH;
        end else if (!pf_valid_reg && mem_ready) begin
          pf_data_next  = mem_rdata;
          pf_valid_next = 1'b1;
          pc_next       = pc_reg + PC_ONE;
        end
`else
        if (instr_ack) begin
          state_next = FETCH;
          if (pc_load_en) pc_next = pc_load_value;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // pc already advanced past the held word, so it is the next fetch address.
  assign mem_addr    = pc_reg;
  assign instr_valid = (state_reg == VALID);
  assign opcode      = ir_reg[7:3];
  assign operand     = ir_reg[2:0];
  assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model of the instruction stream
// predicts each fetch address and presented instruction; a monitor compares.
module tb_fetch_unit;

  logic       clk, rst;
  logic       mem_req, mem_ready, instr_valid, instr_ack, pc_load_en;
  logic [7:0] mem_addr, mem_rdata, instr_pc, pc_load_value;
  logic [4:0] opcode;
  logic [2:0] operand;

  fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr_valid(instr_valid),
    .opcode(opcode), .operand(operand), .instr_pc(instr_pc),
    .instr_ack(instr_ack), .pc_load_en(pc_load_en), .pc_load_value(pc_load_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] word;
  } exp_t;

  logic [7:0] mem [256];
  exp_t       exp_q[$];
  logic [7:0] cur_pc;
  int         errors = 0, checks = 0, presented = 0;
  int         ready_pct = 100, ack_pct = 50;
  bit         auto_ack = 1'b0;
  bit         prev_valid = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the next instruction is the redirect target, else the next sequential word.
  task automatic note_ack();
    logic [7:0] nxt;
    if (instr_valid && instr_ack) begin
      nxt    = pc_load_en ? pc_load_value : cur_pc + 8'd1;
      cur_pc = nxt;
      exp_q.push_back('{nxt, mem[nxt]});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_pc = 8'h00;
    exp_q.push_back('{8'h00, mem[8'h00]});
  endtask

  task automatic tick();
    @(negedge clk);
    mem_ready = mem_req && ($urandom_range(1, 100) <= ready_pct);
    mem_rdata = mem_ready ? mem[mem_addr] : 8'($urandom);
    if (auto_ack) begin
      instr_ack  = ($urandom_range(1, 100) <= ack_pct);
      pc_load_en = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       pc_load_value = 8'hFF;
        1:       pc_load_value = cur_pc;
        default: pc_load_value = 8'($urandom);
      endcase
      note_ack();
    end else begin
      instr_ack  = 1'b0;
      pc_load_en = 1'b0;
    end
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, int'(instr_valid), 1);
  endtask

  task automatic retire(bit load, logic [7:0] target);
    instr_ack     = 1'b1;
    pc_load_en    = load;
    pc_load_value = target;
    note_ack();
  endtask

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) chk("fetch_unexpected", 1, 0);
        else chk("fetch_addr", mem_addr, exp_q[0].pc);
      end
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("instr_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("opcode", opcode, e.word[7:3]);
          chk("operand", operand, e.word[2:0]);
          chk("instr_pc", instr_pc, e.pc);
          presented++;
          $display("instr pc=0x%02h opcode=0x%02h operand=%0d", instr_pc, opcode, operand);
        end
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    int stall;
    rst = 1'b1;
    mem_ready = 1'b0; mem_rdata = 8'h00;
    instr_ack = 1'b0; pc_load_en = 1'b0; pc_load_value = 8'h00;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA5;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_opcode", opcode, 0);

    // Release: one quiet cycle, then same-cycle-ready fetch of 0xA5.
    @(negedge clk);
    rst = 1'b0;
    chk("quiet_cycle", mem_req, 0);
    tick();
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 8'h00);
    tick();
    chk("first_valid", instr_valid, 1);
    chk("first_opcode", opcode, 5'b10100);
    chk("first_operand", operand, 3'b101);
    chk("first_pc", instr_pc, 8'h00);

    // Wait states: address stable, nothing valid until ready.
    retire(1'b0, 8'h00);
    ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", mem_addr, 8'h01);
      chk("wait_valid_low", instr_valid, 0);
    end
    ready_pct = 100;
    tick();
    tick();
    chk("wait_done_valid", instr_valid, 1);
    chk("wait_done_pc", instr_pc, 8'h01);

    // Redirect from 0x05 to 0x40.
    retire(1'b1, 8'h05);
    tick();
    wait_valid("to05_valid");
    chk("at05_pc", instr_pc, 8'h05);
    retire(1'b1, 8'h40);
    tick();
    chk("redir_req", mem_req, 1);
    chk("redir_addr", mem_addr, 8'h40);
    tick();
    chk("redir_pc", instr_pc, 8'h40);

    // Wrap from 0xFF to 0x00.
    retire(1'b1, 8'hFF);
    tick();
    wait_valid("toFF_valid");
    chk("atFF_pc", instr_pc, 8'hFF);
    retire(1'b0, 8'h00);
    tick();
    chk("wrap_addr", mem_addr, 8'h00);
    wait_valid("wrap_valid");

    // Reset in the middle of a stalled fetch at 0x12.
    retire(1'b1, 8'h12);
    ready_pct = 0;
    tick();
    chk("pre_rst_addr", mem_addr, 8'h12);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_addr", mem_addr, 8'h00);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_pc", instr_pc, 0);
    chk("mid_rst_opcode", opcode, 0);
    chk("mid_rst_operand", operand, 0);
    ready_pct = 100;
    tick();
    tick();
    rst = 1'b0;
    chk("post_rst_quiet", mem_req, 0);
    tick();
    chk("post_rst_addr", mem_addr, 8'h00);
    wait_valid("post_rst_valid");
    chk("post_rst_pc", instr_pc, 8'h00);

    // Randomized phase: random wait states, acks, redirects (including to self and 0xFF).
    auto_ack  = 1'b1;
    ready_pct = 60;
    stall = 0;
    for (int c = 0; c < 3000 && stall <= 40; c++) begin
      tick();
      stall = instr_valid ? 0 : stall + 1;
    end
    chk("no_stall", int'(stall <= 40), 1);
    auto_ack = 1'b0;
    tick();
    tick();
    chk("enough_instrs", int'(presented > 200), 1);
    chk("queue_drained", int'(exp_q.size() <= 1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
